// File: rtl/ring_osc_ctrl.sv
// Ring-oscillator frequency measurement controller: enables the ring, lets it
// settle, counts synchronized rising edges over a programmable clk window.
module ring_osc_ctrl #(
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              osc_in,
  output logic              osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // Shared phase timer must hold both the settle length and the window length.
  localparam int unsigned TMR_W = (GATE_W > 8) ? GATE_W : 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              wovf_q, wovf_d;
  logic [2:0]        sync_q;
  logic              rise;
  logic              osc_en_d;
  logic              done_d;
  logic [CNT_W-1:0]  count_d;
  logic              overflow_d;

  // sync_q[1:0] is the 2-flop synchronizer; sync_q[2] holds its previous value.
  assign rise = sync_q[1] & ~sync_q[2];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    gate_d     = gate_q;
    wcnt_d     = wcnt_q;
    wovf_d     = wovf_q;
    osc_en_d   = 1'b0;
    done_d     = 1'b0;
    count_d    = count;
    overflow_d = overflow;

    case (state_q)
      IDLE: begin
        if (start) begin
          wcnt_d = '0;
          wovf_d = 1'b0;
          if (gate_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = SETTLE;
            gate_d  = gate_len;
            tmr_d   = TMR_W'(SETTLE_CYC - 1);
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = MEASURE;
          tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      MEASURE: begin
        // Saturate rather than wrap; an edge beyond full scale flags overflow.
        if (rise) begin
          if (wcnt_q == '1) begin
            wovf_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end
        end
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    osc_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    done_d   = (state_d == DONE);
    if (done_d) begin
      count_d    = wcnt_d;
      overflow_d = wovf_d;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      gate_q   <= '0;
      wcnt_q   <= '0;
      wovf_q   <= 1'b0;
      sync_q   <= '0;
      osc_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      gate_q   <= gate_d;
      wcnt_q   <= wcnt_d;
      wovf_q   <= wovf_d;
      sync_q   <= {sync_q[1:0], osc_in};
      osc_en   <= osc_en_d;
      busy     <= osc_en_d;
      done     <= done_d;
      count    <= count_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Bench for ring_osc_ctrl: two instances (16-bit and 4-bit counters) share
// stimulus and are checked every cycle against a schedule-based model.
module tb_ring_osc_ctrl;

  localparam int S     = 8;
  localparam int HLEN  = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] gate_len;
  logic        osc_in = 1'b0;

  logic        osc_en16, busy16, done16, ovf16;
  logic [15:0] count16;
  logic        osc_en4, busy4, done4, ovf4;
  logic [3:0]  count4;

  int n_cmp = 0;
  int n_bad = 0;

  ring_osc_ctrl #(.GATE_W(16), .CNT_W(16), .SETTLE_CYC(S)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en16), .busy(busy16), .done(done16),
    .count(count16), .overflow(ovf16)
  );

  ring_osc_ctrl #(.GATE_W(16), .CNT_W(4), .SETTLE_CYC(S)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_in(osc_in), .osc_en(osc_en4), .busy(busy4), .done(done4),
    .count(count4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: toggles every osc_half clk periods, offset from clk.
  int osc_half = 0;
  int osc_cnt  = 0;
  always @(negedge clk) begin
    #1;
    if (osc_half == 0) begin
      osc_in  = 1'b0;
      osc_cnt = 0;
    end else begin
      osc_cnt++;
      if (osc_cnt >= osc_half) begin
        osc_in  = ~osc_in;
        osc_cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge a with window g keeps the ring enabled
  // after edges a..a+S+g-1 and pulses done after edge a+S+g (edge a if g==0).
  // The result is the number of 0->1 steps in the osc history seen two edges
  // late, over the g measurement cycles.
  bit hist [0:HLEN-1];
  int n        = 0;
  int acc      = 0;
  int g        = 0;
  int done_e   = -1;
  int free_at  = 0;
  bit act      = 1'b0;
  bit e_en     = 1'b0;
  bit e_done   = 1'b0;
  int e_c16    = 0;
  int e_o16    = 0;
  int e_c4     = 0;
  int e_o4     = 0;

  always @(posedge clk) begin
    bit busy_prev;
    int raw;
    if (n < HLEN) hist[n] = osc_in;
    e_done = 1'b0;
    busy_prev = act && (g != 0) && (n - 1 >= acc) && (n - 1 <= acc + S + g - 1);
    if (rst) begin
      act = 1'b0; free_at = n + 1;
      e_c16 = 0; e_o16 = 0; e_c4 = 0; e_o4 = 0;
    end else if (busy_prev && abort) begin
      act = 1'b0; free_at = n + 1;
    end else if (start && n >= free_at) begin
      acc = n; g = int'(gate_len); act = 1'b1;
      done_e  = (g == 0) ? n : n + S + g;
      free_at = done_e + 2;
    end
    e_en = act && (g != 0) && (n >= acc) && (n <= acc + S + g - 1);
    if (!rst && act && n == done_e) begin
      e_done = 1'b1;
      raw = 0;
      for (int m = n - g; m < n; m++)
        if (hist[m-1] && !hist[m-2]) raw++;
      e_c16 = (raw > 65535) ? 65535 : raw;
      e_o16 = (raw > 65535) ? 1 : 0;
      e_c4  = (raw > 15) ? 15 : raw;
      e_o4  = (raw > 15) ? 1 : 0;
    end
    n++;
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (n > 0) begin
      chk("osc_en16", 32'(osc_en16), 32'(e_en));
      chk("busy16",   32'(busy16),   32'(e_en));
      chk("done16",   32'(done16),   32'(e_done));
      chk("count16",  32'(count16),  32'(e_c16));
      chk("ovf16",    32'(ovf16),    32'(e_o16));
      chk("osc_en4",  32'(osc_en4),  32'(e_en));
      chk("busy4",    32'(busy4),    32'(e_en));
      chk("done4",    32'(done4),    32'(e_done));
      chk("count4",   32'(count4),   32'(e_c4));
      chk("ovf4",     32'(ovf4),     32'(e_o4));
    end
  end

  // Issue a request and wait (bounded) for done, counting busy cycles.
  // Optionally re-pulses start with another length inj_at cycles in.
  task automatic run(input int gl, input int inj_at, input int inj_gl,
                     output int bc, output bit gd);
    @(negedge clk);
    start = 1'b1; gate_len = 16'(gl);
    @(negedge clk);
    start = 1'b0;
    bc = 0; gd = 1'b0;
    for (int i = 0; i < gl + S + 40; i++) begin
      if (inj_at > 0 && i == inj_at) begin
        start = 1'b1; gate_len = 16'(inj_gl);
      end else begin
        start = 1'b0;
      end
      if (busy16) bc++;
      if (done16) begin
        gd = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(gd), 32'd1);
  endtask

  initial begin
    int bc;
    bit gd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count16), 32'd0);
    chk("rst_osc_en", 32'(osc_en16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic window: 100 cycles, osc period 10 clk.
    osc_half = 5;
    run(100, 0, 0, bc, gd);
    chk("basic_busy_cycles", 32'(bc), 32'd108);
    chk("basic_count16", 32'(count16), 32'd10);
    chk("basic_ovf16", 32'(ovf16), 32'd0);
    chk("basic_count4", 32'(count4), 32'd10);
    @(negedge clk);
    chk("basic_done_one_cycle", 32'(done16), 32'd0);

    // Zero-length window: straight to done, ring never enabled.
    @(negedge clk);
    start = 1'b1; gate_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done16), 32'd1);
    chk("zero_osc_en", 32'(osc_en16), 32'd0);
    chk("zero_count", 32'(count16), 32'd0);
    @(negedge clk);
    chk("zero_done_clear", 32'(done16), 32'd0);

    // Saturation: 50 edges into a 4-bit counter.
    osc_half = 2;
    run(200, 0, 0, bc, gd);
    chk("sat_busy_cycles", 32'(bc), 32'd208);
    chk("sat_count4", 32'(count4), 32'd15);
    chk("sat_ovf4", 32'(ovf4), 32'd1);
    chk("sat_count16", 32'(count16), 32'd50);
    chk("sat_ovf16", 32'(ovf16), 32'd0);

    // 20 edges: fits 16 bits, still saturates 4 bits.
    osc_half = 5;
    run(200, 0, 0, bc, gd);
    chk("e20_count16", 32'(count16), 32'd20);
    chk("e20_ovf16", 32'(ovf16), 32'd0);
    chk("e20_ovf4", 32'(ovf4), 32'd1);

    // Abort 30 cycles into MEASURE, then restart immediately.
    @(negedge clk);
    start = 1'b1; gate_len = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_osc_en", 32'(osc_en16), 32'd0);
    chk("abort_done", 32'(done16), 32'd0);
    chk("abort_count_kept", 32'(count16), 32'd20);
    start = 1'b1; gate_len = 16'd20;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy16), 32'd1);
    for (int i = 0; i < 60 && !done16; i++) @(negedge clk);
    chk("restart_done", 32'(done16), 32'd1);
    chk("restart_count", 32'(count16), 32'd2);

    // start with abort in IDLE is accepted; abort in SETTLE returns to idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; gate_len = 16'd30;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy16), 32'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("settle_abort_osc_en", 32'(osc_en16), 32'd0);
    chk("settle_abort_count", 32'(count16), 32'd2);

    // start while busy is ignored: window stays 50.
    run(50, S + 10, 10, bc, gd);
    chk("busy_start_cycles", 32'(bc), 32'd58);
    chk("busy_start_count", 32'(count16), 32'd5);

    // Reset mid-MEASURE clears everything, no done follows.
    @(negedge clk);
    start = 1'b1; gate_len = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_osc_en", 32'(osc_en16), 32'd0);
    chk("rst_mid_busy", 32'(busy16), 32'd0);
    chk("rst_mid_count16", 32'(count16), 32'd0);
    chk("rst_mid_ovf4", 32'(ovf4), 32'd0);
    repeat (120) @(negedge clk);

    // Recovery after reset.
    run(100, 0, 0, bc, gd);
    chk("recover_count", 32'(count16), 32'd10);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
